fk_waypoint_sequencer: RTL
==========================

// Module: fk_waypoint_sequencer
// PURPOSE
//  Sequences the combinational forward-kinematics datapath (fk_* ports).
//  - Buffers joint-angle waypoints in a small FIFO.
//  - Issues one waypoint at a time to the FK block, waits a fixed settle time, captures X/Y.
//  - Presents each X/Y result on a valid/ready output with an angle-legality flag.
//  Sits between the trajectory/command source and the FK datapath; the FK block is instantiated alongside it.
// PARAMETERS
//  ANGLE_W     16  joint angle width in degrees, signed
//  LEN_W       16  link length width, signed
//  POS_W       32  X/Y result width, signed
//  DEPTH       4   waypoint FIFO entries; power of 2, >=2
//  FK_LATENCY  1   settle cycles allowed for the FK datapath; >=1
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous active-low reset
//  wp_valid        in   1        waypoint offered
//  wp_ready        out  1        FIFO can accept a waypoint
//  wp_theta1..3    in   ANGLE_W  waypoint joint angles, degrees
//  cfg_l1..3       in   LEN_W    link lengths; sampled at issue
//  fk_theta1..3    out  ANGLE_W  registered angles driven to the FK block
//  fk_l1..3        out  LEN_W    registered lengths driven to the FK block
//  fk_x, fk_y      in   POS_W    FK block results
//  pos_valid       out  1        result available
//  pos_ready       in   1        consumer accepts result
//  pos_x, pos_y    out  POS_W    captured result
//  pos_bad_angle   out  1        result derived from an angle outside the FK table
//  busy            out  1        FSM not IDLE, or FIFO non-empty
//  fifo_count      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO flushed; state IDLE; all outputs 0, including wp_ready.
//   wp_ready = (fifo_count < DEPTH), taken from the registered count from the first edge after reset.
//   An async assert mid-operation aborts any in-flight waypoint; no result is produced for it.
//  FIFO: push on wp_valid & wp_ready.
//   Pop only in ISSUE. A simultaneous push and pop leaves the count unchanged.
//   No overflow/underflow is possible. Pointers wrap modulo DEPTH.
//  FSM states: IDLE, ISSUE, SETTLE, PRESENT.
//   IDLE   : fifo_count>0 -> ISSUE.
//   ISSUE  : pop the head; register fk_theta* <= head and fk_l* <= cfg_l*;
//            load settle counter = FK_LATENCY; -> SETTLE.
//   SETTLE : decrement each cycle. On the cycle the counter is 1:
//            capture pos_x/pos_y <= fk_x/fk_y, compute pos_bad_angle, set pos_valid; -> PRESENT.
//   PRESENT: hold pos_* stable while pos_valid & !pos_ready.
//            On pos_ready: clear pos_valid; -> ISSUE if fifo_count>0
//            (count before any same-cycle push), else -> IDLE.
//  Latency: waypoint accepted at edge 0 with FSM IDLE and FIFO empty
//   -> pos_valid rises at edge FK_LATENCY+2.
//  Throughput under continuous pos_ready: one result per FK_LATENCY+2 cycles.
//  fk_* outputs hold the last issued values until the next ISSUE.
//  pos_bad_angle: 1 if any of t1, t1+t2, t1+t2+t3 (ANGLE_W-bit wrap sum)
//   is not in {0,30,45,60,90,120,135,150,180}. The result is still presented.
//  cfg_l* changes after ISSUE do not affect the in-flight waypoint.
// CONFIGURATION
//  FK_REACH_CHECK_EN defined:
//   - Adds output pos_out_of_reach (1 bit), registered with pos_x/pos_y.
//   - Asserted when pos_x^2+pos_y^2 > (l1+l2+l3)^2, using the issued lengths.
//   - Squares computed at 2*POS_W+1 bits, signed-safe. Reset value 0.
//  FK_REACH_CHECK_EN undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING (bench instantiates the FK datapath; cfg_l1..3 = 100,100,100; FK_LATENCY=1)
//  1. Push (0,0,0) from idle, pos_ready=1 -> pos_valid at edge 3; X=300, Y=0, bad=0.
//  2. Push (30,30,30) -> X=136, Y=236, bad=0; then (0,90,0) -> X=100, Y=200, in order.
//  3. Push (10,0,0) -> bad=1, X=100, Y=0 (FK default entries), result still presented.
//  4. Backpressure: pos_ready=0, wp_valid held 1 -> exactly 5 waypoints accepted,
//     then wp_ready=0 and fifo_count=4.
//     Raise pos_ready -> all 5 results delivered in order; wp_ready reasserts after the first pop.
//  5. Reset asserted during SETTLE with 2 entries queued -> pos_valid=0, fifo_count=0, busy=0
//     immediately; no stale result after release.
//  6. FK_REACH_CHECK_EN: force fk_x=400, fk_y=0 -> pos_out_of_reach=1;
//     fk_x=300, fk_y=0 -> 0.

Source files
------------

// File: rtl/fk_waypoint_sequencer_if.sv
// fk_waypoint_sequencer_if: waypoint input and position output handshakes.
// Optional: FK_REACH_CHECK_EN adds pos_out_of_reach to the position channel.
interface fk_waypoint_sequencer_if #(
    parameter int unsigned ANGLE_W = 16,
    parameter int unsigned POS_W   = 32
);
    logic                      wp_valid;
    logic                      wp_ready;
    logic signed [ANGLE_W-1:0] wp_theta1;
    logic signed [ANGLE_W-1:0] wp_theta2;
    logic signed [ANGLE_W-1:0] wp_theta3;
    logic                      pos_valid;
    logic                      pos_ready;
    logic signed [POS_W-1:0]   pos_x;
    logic signed [POS_W-1:0]   pos_y;
    logic                      pos_bad_angle;
`ifdef FK_REACH_CHECK_EN
    logic                      pos_out_of_reach;

    modport master (
        output wp_valid, wp_theta1, wp_theta2, wp_theta3, pos_ready,
        input  wp_ready, pos_valid, pos_x, pos_y, pos_bad_angle, pos_out_of_reach
    );
    modport slave (
        input  wp_valid, wp_theta1, wp_theta2, wp_theta3, pos_ready,
        output wp_ready, pos_valid, pos_x, pos_y, pos_bad_angle, pos_out_of_reach
    );
`else
    modport master (
        output wp_valid, wp_theta1, wp_theta2, wp_theta3, pos_ready,
        input  wp_ready, pos_valid, pos_x, pos_y, pos_bad_angle
    );
    modport slave (
        input  wp_valid, wp_theta1, wp_theta2, wp_theta3, pos_ready,
        output wp_ready, pos_valid, pos_x, pos_y, pos_bad_angle
    );
`endif
endinterface

// File: rtl/fk_waypoint_sequencer.sv
// fk_waypoint_sequencer: buffers joint-angle waypoints, issues them one at a time to the
// combinational FK datapath, waits FK_LATENCY cycles, and presents the captured X/Y result.
// Optional: define FK_REACH_CHECK_EN to add the pos_out_of_reach flag.
module fk_waypoint_sequencer #(
    parameter int unsigned ANGLE_W    = 16,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned POS_W      = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FK_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fk_waypoint_sequencer_if.slave    bus,
    input  logic signed [LEN_W-1:0]   cfg_l1,
    input  logic signed [LEN_W-1:0]   cfg_l2,
    input  logic signed [LEN_W-1:0]   cfg_l3,
    output logic signed [ANGLE_W-1:0] fk_theta1,
    output logic signed [ANGLE_W-1:0] fk_theta2,
    output logic signed [ANGLE_W-1:0] fk_theta3,
    output logic signed [LEN_W-1:0]   fk_l1,
    output logic signed [LEN_W-1:0]   fk_l2,
    output logic signed [LEN_W-1:0]   fk_l3,
    input  logic signed [POS_W-1:0]   fk_x,
    input  logic signed [POS_W-1:0]   fk_y,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(FK_LATENCY + 1);
    localparam int unsigned EW = 3 * ANGLE_W;

    typedef enum logic [1:0] {StIdle, StIssue, StSettle, StPresent} state_e;

    state_e                    state_q, state_d;
    logic [EW-1:0]             mem_q [DEPTH];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic                      ready_en_q;
    logic [SW-1:0]             settle_q;
    logic                      push, pop, capture, deliver;
    logic [EW-1:0]             head;
    logic signed [ANGLE_W-1:0] theta1_q, theta2_q, theta3_q;
    logic signed [LEN_W-1:0]   l1_q, l2_q, l3_q;
    logic signed [POS_W-1:0]   pos_x_q, pos_y_q;
    logic                      pos_valid_q, pos_bad_q;
    logic [ANGLE_W-1:0]        sum2, sum3;
    logic                      bad_angle;

    // Angles the FK table covers; anything else falls to its default entries.
    function automatic logic angle_legal(input logic [ANGLE_W-1:0] a);
        return a inside {ANGLE_W'(0), ANGLE_W'(30), ANGLE_W'(45), ANGLE_W'(60), ANGLE_W'(90),
                         ANGLE_W'(120), ANGLE_W'(135), ANGLE_W'(150), ANGLE_W'(180)};
    endfunction

    // wp_ready stays low until the first edge after reset release.
    assign bus.wp_ready = ready_en_q && (count_q < CW'(DEPTH));
    assign push         = bus.wp_valid && bus.wp_ready;
    assign head         = mem_q[rd_ptr_q];
    assign fifo_count   = count_q;
    assign busy         = (state_q != StIdle) || (count_q != '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next state and per-state strobes.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        deliver = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                pop     = 1'b1;
                state_d = StSettle;
            end
            StSettle: begin
                if (settle_q == SW'(1)) begin
                    capture = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (bus.pos_ready) begin
                    deliver = 1'b1;
                    // count_q is the pre-push occupancy, so a same-cycle push waits for IDLE.
                    state_d = (count_q != '0) ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO storage; pointer reset alone flushes it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.wp_theta3, bus.wp_theta2, bus.wp_theta1};
    end

    // FIFO pointers, occupancy and ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    assign sum2      = ANGLE_W'(theta1_q + theta2_q);
    assign sum3      = ANGLE_W'(sum2 + theta3_q);
    assign bad_angle = !(angle_legal(theta1_q) && angle_legal(sum2) && angle_legal(sum3));

    // Issue registers, settle counter and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta1_q    <= '0;
            theta2_q    <= '0;
            theta3_q    <= '0;
            l1_q        <= '0;
            l2_q        <= '0;
            l3_q        <= '0;
            settle_q    <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pos_bad_q   <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                theta1_q <= head[ANGLE_W-1:0];
                theta2_q <= head[2*ANGLE_W-1:ANGLE_W];
                theta3_q <= head[EW-1:2*ANGLE_W];
                l1_q     <= cfg_l1;
                l2_q     <= cfg_l2;
                l3_q     <= cfg_l3;
                settle_q <= SW'(FK_LATENCY);
            end else if (state_q == StSettle) begin
                settle_q <= settle_q - SW'(1);
            end
            if (capture) begin
                pos_x_q     <= fk_x;
                pos_y_q     <= fk_y;
                pos_bad_q   <= bad_angle;
                pos_valid_q <= 1'b1;
            end else if (deliver) begin
                pos_valid_q <= 1'b0;
            end
        end
    end

    assign fk_theta1         = theta1_q;
    assign fk_theta2         = theta2_q;
    assign fk_theta3         = theta3_q;
    assign fk_l1             = l1_q;
    assign fk_l2             = l2_q;
    assign fk_l3             = l3_q;
    assign bus.pos_valid     = pos_valid_q;
    assign bus.pos_x         = pos_x_q;
    assign bus.pos_y         = pos_y_q;
    assign bus.pos_bad_angle = pos_bad_q;

`ifdef FK_REACH_CHECK_EN
    localparam int unsigned RW = 2 * POS_W + 1;

    logic signed [RW-1:0] x_ext, y_ext, l_ext, mag_sq, reach_sq;
    logic                 reach_q;

    // Squared distance versus squared total arm length, wide enough to never overflow.
    always_comb begin
        x_ext    = RW'(fk_x);
        y_ext    = RW'(fk_y);
        l_ext    = RW'(l1_q) + RW'(l2_q) + RW'(l3_q);
        mag_sq   = x_ext * x_ext + y_ext * y_ext;
        reach_sq = l_ext * l_ext;
    end

    // Reach flag is captured alongside pos_x/pos_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       reach_q <= 1'b0;
        else if (capture) reach_q <= (mag_sq > reach_sq);
    end

    assign bus.pos_out_of_reach = reach_q;
`endif
endmodule
